// File: rtl/ldpc_cnp_defs_pkg.sv
// Shared check-node definitions: control FSM state encodings, pass timeout default
// and the decoded control-word layout used by the min/second-min control path.
package ldpc_cnp_defs_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_FIRST  = 3'd2;
   localparam logic [2:0] S_INIT2  = 3'd3;
   localparam logic [2:0] S_SECOND = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int unsigned PASS_TIMEOUT_DEFAULT = 5;
   localparam int unsigned PASS_CNT_W           = 3;

   typedef struct packed {
      logic initialize_min;
      logic initialize_second_min;
      logic reset_count;
      logic calculating_second_min;
      logic load_first_min;
      logic load_second_min;
      logic busy;
      logic done;
      logic error;
   } cnp_ctrl_t;

   function automatic logic is_pass_state(input logic [2:0] s);
      return (s == S_FIRST) || (s == S_SECOND);
   endfunction

endpackage

// File: rtl/pass_cycle_counter.sv
// Cycle counter for one comparison pass: synchronous clear, count enable, and a
// terminal flag raised when the counter has saturated at all-ones.
module pass_cycle_counter #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !terminal) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign terminal = &count_q;

endmodule

// File: rtl/minimum_second_minimum_calculator_control_path.sv
// Control FSM for the min/second-min datapath: an initialise cycle, a first pass that
// finds the minimum and its position, a second pass for the runner-up, then a done pulse.
module minimum_second_minimum_calculator_control_path
   import ldpc_cnp_defs_pkg::*;
#(
   parameter int unsigned PASS_TIMEOUT = PASS_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic done_iterations,
   output logic initialize_min,
   output logic initialize_second_min,
   output logic reset_count,
   output logic calculating_second_min,
   output logic load_first_min,
   output logic load_second_min,
   output logic busy,
   output logic done,
   output logic error
);

   // Count value seen in the last cycle a pass may occupy (count is 0 in its first cycle).
   localparam logic [PASS_CNT_W-1:0] PASS_LAST = PASS_CNT_W'(PASS_TIMEOUT - 1);

   logic [STATE_W-1:0]    state_q, state_d;
   logic                  timed_out_q, timed_out_d;
   logic                  in_pass;
   logic                  pass_expired;
   logic [PASS_CNT_W-1:0] pass_count;
   logic                  pass_saturated;
   cnp_ctrl_t             ctrl;

   assign in_pass = is_pass_state(state_q);

   pass_cycle_counter #(
      .WIDTH (PASS_CNT_W)
   ) u_pass_cycle_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (!in_pass),
      .enable   (in_pass),
      .count    (pass_count),
      .terminal (pass_saturated)
   );

   // Saturation also ends the pass so a timeout beyond the counter range cannot hang.
   assign pass_expired = in_pass && ((pass_count == PASS_LAST) || pass_saturated);

   always_comb begin
      state_d     = state_q;
      timed_out_d = timed_out_q;
      case (state_q)
         S_IDLE: begin
            timed_out_d = 1'b0;
            if (start) state_d = S_INIT;
         end
         S_INIT:  state_d = S_FIRST;
         S_FIRST: begin
            if (done_iterations) begin
               state_d = S_INIT2;
            end else if (pass_expired) begin
               state_d     = S_DONE;
               timed_out_d = 1'b1;
            end
         end
         S_INIT2: state_d = S_SECOND;
         S_SECOND: begin
            if (done_iterations) begin
               state_d = S_DONE;
            end else if (pass_expired) begin
               state_d     = S_DONE;
               timed_out_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            timed_out_d = 1'b0;
         end
         default: begin
            state_d     = S_IDLE;
            timed_out_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timed_out_q <= timed_out_d;
      end
   end

   // Loads drop once the datapath reports completion or the pass has run out of time.
   always_comb begin
      ctrl                        = '0;
      ctrl.initialize_min         = (state_q == S_INIT);
      ctrl.initialize_second_min  = (state_q == S_INIT);
      ctrl.reset_count            = (state_q == S_INIT) || (state_q == S_INIT2);
      ctrl.calculating_second_min = (state_q == S_INIT2) || (state_q == S_SECOND);
      ctrl.load_first_min         = (state_q == S_FIRST) && !done_iterations && !pass_expired;
      ctrl.load_second_min        = (state_q == S_SECOND) && !done_iterations && !pass_expired;
      ctrl.busy                   = (state_q != S_IDLE);
      ctrl.done                   = (state_q == S_DONE);
      ctrl.error                  = (state_q == S_DONE) && timed_out_q;
   end

   assign initialize_min         = ctrl.initialize_min;
   assign initialize_second_min  = ctrl.initialize_second_min;
   assign reset_count            = ctrl.reset_count;
   assign calculating_second_min = ctrl.calculating_second_min;
   assign load_first_min         = ctrl.load_first_min;
   assign load_second_min        = ctrl.load_second_min;
   assign busy                   = ctrl.busy;
   assign done                   = ctrl.done;
   assign error                  = ctrl.error;

endmodule
